mux16_scan_ctrl: RTL

//   Sequential scan controller wrapped around the 16:1 structural mux. Drives the mux

---
 rtl/mux16_scan_ctrl_pkg.sv | 13 +
 rtl/mux16_scan_ctrl_if.sv | 23 ++
 rtl/mux16_scan_ctrl_settle_timer.sv | 29 ++
 rtl/mux16_scan_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/mux16_scan_ctrl_pkg.sv
// Shared constants for the 16-channel mux scan controller: widths, settle limit
// and the legacy 2-bit FSM state encoding.
package mux_scan_pkg;
  localparam int unsigned N_CH       = 16;
  localparam int unsigned SEL_W      = 4;
  localparam int unsigned SETTLE_MAX = 15;
  localparam int unsigned CNT_W      = $clog2(SETTLE_MAX + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
endpackage

// File: rtl/mux16_scan_ctrl_if.sv
// Bundle between the scan controller (slave) and its requester/mux side (master).
interface mux16_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic              start;
  logic [N_CH-1:0]   mask;
  logic [SEL_W-1:0]  sel;
  logic              mux_out;
  logic [N_CH-1:0]   word;
  logic              word_valid;
  logic              word_ready;
  logic              busy;

  modport master (
    output start, mask, mux_out, word_ready,
    input  sel, word, word_valid, busy
  );

  modport slave (
    input  start, mask, mux_out, word_ready,
    output sel, word, word_valid, busy
  );
endinterface

// File: rtl/mux16_scan_ctrl_settle_timer.sv
// Settle-window counter: cleared on load, counts while enabled, flags the last
// settle cycle of the current channel.
module scan_settle_timer
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);
  localparam logic [CNT_W-1:0] LAST = (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_count && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == LAST);
endmodule

// File: rtl/mux16_scan_ctrl.sv
// Scan controller: walks the 16:1 mux select, waits SETTLE cycles per enabled
// channel, samples mux_out into a word and offers it over valid/ready.
module mux16_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mux16_scan_ctrl_if.slave   bus
);
  if (SETTLE > SETTLE_MAX) begin : g_bad_settle
    $error("mux16_scan_ctrl: SETTLE=%0d exceeds maximum %0d", SETTLE, SETTLE_MAX);
  end

  localparam bit ZERO_SETTLE = (SETTLE == 0);

  logic [1:0]       r_state;
  logic [SEL_W-1:0] r_sel;
  logic [N_CH-1:0]  r_mask_q;
  logic [N_CH-1:0]  r_shadow;
  logic [N_CH-1:0]  r_word;
  logic             r_valid;

  logic [SEL_W-1:0] w_next_sel;
  logic [N_CH-1:0]  w_merged;
  logic             w_en;
  logic             w_last;
  logic             w_advance;
  logic             w_bit;
  logic             w_load;
  logic             w_expire;

  // Disabled channels and finished samples share one advance path; the bit
  // written into the shadow is 0 for a skipped channel.
  always_comb begin
    w_en              = r_mask_q[r_sel];
    w_last            = (r_sel == SEL_W'(N_CH - 1));
    w_next_sel        = r_sel + 1'b1;
    w_advance         = (r_state == ST_SAMPLE) || ((r_state == ST_SETTLE) && !w_en);
    w_bit             = (r_state == ST_SAMPLE) ? bus.mux_out : 1'b0;
    w_merged          = r_shadow;
    w_merged[r_sel]   = w_bit;
    w_load            = w_advance || ((r_state == ST_IDLE) && bus.start);
  end

  scan_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_count  (r_state == ST_SETTLE),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_mask_q <= '0;
      r_shadow <= '0;
      r_word   <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_mask_q <= bus.mask;
            r_shadow <= '0;
            r_sel    <= '0;
            r_state  <= (ZERO_SETTLE && bus.mask[0]) ? ST_SAMPLE : ST_SETTLE;
          end
        end
        ST_SETTLE, ST_SAMPLE: begin
          if (w_advance) begin
            r_shadow <= w_merged;
            if (w_last) begin
              r_word  <= w_merged;
              r_valid <= 1'b1;
              r_sel   <= '0;
              r_state <= ST_DONE;
            end else begin
              r_sel   <= w_next_sel;
              r_state <= (ZERO_SETTLE && r_mask_q[w_next_sel]) ? ST_SAMPLE : ST_SETTLE;
            end
          end else if (w_expire) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_DONE: begin
          if (bus.word_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sel        = r_sel;
  assign bus.word       = r_word;
  assign bus.word_valid = r_valid;
  assign bus.busy       = (r_state != ST_IDLE);
endmodule
